// File: rtl/keccak_squeeze_reader.sv
// keccak_squeeze_reader
// Consumer-side companion to the Keccak core. Captures each rate block the
// core presents, serialises it into 64-bit words on a valid/ready stream, and
// keeps the core squeezing until the requested word count has been delivered.
module keccak_squeeze_reader #(
    parameter int RATE_XOF   = 21,
    parameter int RATE_OTHER = 17,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [CNT_W-1:0]         req_words,
    input  logic [64*RATE_XOF-1:0]   blk_in,
    input  logic                     blk_valid,
    output logic                     squeeze,
    output logic                     sha_hold,
    output logic [63:0]              dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     dout_last,
    output logic                     busy,
    output logic                     done
);

    localparam logic [1:0]       MODE_XOF      = 2'b00;
    localparam logic [4:0]       LAST_IDX_XOF  = 5'(RATE_XOF - 1);
    localparam logic [4:0]       LAST_IDX_OTH  = 5'(RATE_OTHER - 1);
    localparam logic [CNT_W-1:0] BLK_WORDS_XOF = CNT_W'(RATE_XOF);
    localparam logic [CNT_W-1:0] BLK_WORDS_OTH = CNT_W'(RATE_OTHER);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BLK = 2'd1,
        DRAIN    = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                   state, state_next;
    logic [1:0]               mode_q;
    logic [CNT_W-1:0]         remaining;
    logic [4:0]               word_idx;
    logic [64*RATE_XOF-1:0]   buffer;

    logic                     is_xof;
    logic                     more_blocks;
    logic [4:0]               last_idx;
    logic                     word_fire;
    logic [CNT_W-1:0]         start_words;

    assign is_xof      = (mode_q == MODE_XOF);
    // Only XOF sessions span blocks; other modes take exactly one block.
    assign more_blocks = is_xof && (remaining > BLK_WORDS_XOF);
    assign last_idx    = is_xof ? LAST_IDX_XOF : LAST_IDX_OTH;
    assign word_fire   = (state == DRAIN) && dout_ready;
    // Fixed-rate modes cannot deliver more than one block, so clamp up front
    // and let dout_last fall naturally on the final word of that block.
    assign start_words = ((mode != MODE_XOF) && (req_words > BLK_WORDS_OTH))
                         ? BLK_WORDS_OTH : req_words;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (req_words == '0) ? DONE : WAIT_BLK;
                end
            end
            WAIT_BLK: begin
                if (blk_valid) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (word_fire) begin
                    if (remaining == CNT_W'(1)) begin
                        state_next = DONE;
                    end else if (word_idx == last_idx) begin
                        state_next = WAIT_BLK;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Session datapath: latched mode, word counters and the captured block.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_XOF;
            remaining <= '0;
            word_idx  <= '0;
            // NOTE: the block buffer is a plain register (not a RAM), so it
            // can be cleared on reset; dout is also gated outside DRAIN.
            buffer    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (req_words != '0)) begin
                        mode_q    <= mode;
                        remaining <= start_words;
                        word_idx  <= '0;
                    end
                end
                WAIT_BLK: begin
                    if (blk_valid) begin
                        buffer   <= blk_in;
                        word_idx <= '0;
                    end
                end
                DRAIN: begin
                    if (dout_ready) begin
                        remaining <= remaining - CNT_W'(1);
                        word_idx  <= (word_idx == last_idx) ? 5'd0 : word_idx + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from the current state.
    always_comb begin
        squeeze    = 1'b0;
        sha_hold   = 1'b0;
        dout       = '0;
        dout_valid = 1'b0;
        dout_last  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            WAIT_BLK: begin
                busy    = 1'b1;
                squeeze = more_blocks;
            end
            DRAIN: begin
                busy       = 1'b1;
                squeeze    = more_blocks;
                sha_hold   = 1'b1;
                dout_valid = 1'b1;
                dout       = buffer[{word_idx, 6'd0} +: 64];
                dout_last  = (remaining == CNT_W'(1));
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_keccak_squeeze_reader.sv
// Directed testbench for keccak_squeeze_reader. Inputs are driven and outputs
// sampled on the falling clock edge; the DUT registers on the rising edge.
module tb_keccak_squeeze_reader;

    localparam int RATE_XOF   = 21;
    localparam int RATE_OTHER = 17;
    localparam int CNT_W      = 16;

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic [1:0]             mode;
    logic [CNT_W-1:0]       req_words;
    logic [64*RATE_XOF-1:0] blk_in;
    logic                   blk_valid;
    logic                   squeeze;
    logic                   sha_hold;
    logic [63:0]            dout;
    logic                   dout_valid;
    logic                   dout_ready;
    logic                   dout_last;
    logic                   busy;
    logic                   done;

    int checks   = 0;
    int failures = 0;

    keccak_squeeze_reader #(
        .RATE_XOF   (RATE_XOF),
        .RATE_OTHER (RATE_OTHER),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .req_words  (req_words),
        .blk_in     (blk_in),
        .blk_valid  (blk_valid),
        .squeeze    (squeeze),
        .sha_hold   (sha_hold),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block whose word k equals base + k.
    function automatic logic [64*RATE_XOF-1:0] make_blk(input logic [63:0] base);
        logic [64*RATE_XOF-1:0] b;
        b = '0;
        for (int k = 0; k < RATE_XOF; k++) begin
            b[64*k +: 64] = base + 64'(k);
        end
        return b;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Issue a one-cycle start; returns on the cycle after start was sampled.
    task automatic issue_start(input logic [1:0] m, input int n);
        start     = 1'b1;
        mode      = m;
        req_words = CNT_W'(n);
        step();
        start     = 1'b0;
    endtask

    // Present a block for one cycle; returns on the first DRAIN cycle.
    task automatic present_block(input logic [63:0] base);
        blk_in    = make_blk(base);
        blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        blk_in    = make_blk(64'hDEAD_0000);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({busy, done, dout_valid, dout_last, squeeze, sha_hold} !== 6'b0 || dout !== 64'd0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b dv=%b last=%b sq=%b hold=%b dout=%h, want all 0",
                     busy, done, dout_valid, dout_last, squeeze, sha_hold, dout);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_xof_single();
        dout_ready = 1'b1;
        issue_start(2'b00, 5);
        checks++;
        if (busy !== 1'b1 || dout_valid !== 1'b0 || squeeze !== 1'b0 || sha_hold !== 1'b0) begin
            failures++;
            $display("FAIL single_wait: busy=%b dv=%b sq=%b hold=%b, want 1 0 0 0", busy, dout_valid, squeeze, sha_hold);
        end
        present_block(64'd1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== 64'(i + 1) || dout_last !== (i == 4) ||
                sha_hold !== 1'b1 || squeeze !== 1'b0) begin
                failures++;
                $display("FAIL single_word%0d: dv=%b dout=%0d last=%b hold=%b sq=%b, want 1 %0d %b 1 0",
                         i, dout_valid, dout, dout_last, sha_hold, squeeze, i + 1, (i == 4));
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_done: done=%b busy=%b dv=%b, want 1 0 0", done, busy, dout_valid);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL single_done_pulse: done=%b, want 0", done);
        end
    endtask

    task automatic test_xof_multi();
        int rem;
        int nwords;
        logic [63:0] base;
        rem = 50;
        dout_ready = 1'b1;
        issue_start(2'b00, 50);
        for (int b = 0; b < 3; b++) begin
            base = 64'(100 * (b + 1));
            checks++;
            if (dout_valid !== 1'b0 || sha_hold !== 1'b0 || squeeze !== (rem > 21)) begin
                failures++;
                $display("FAIL multi_wait%0d: dv=%b hold=%b sq=%b, want 0 0 %b", b, dout_valid, sha_hold, squeeze, (rem > 21));
            end
            present_block(base);
            nwords = (rem > 21) ? 21 : rem;
            for (int i = 0; i < nwords; i++) begin
                // The core's output changes mid-drain; the buffer must hide it.
                if (b == 0 && i == 3) begin
                    blk_valid = 1'b1;
                end else begin
                    blk_valid = 1'b0;
                end
                checks++;
                if (dout_valid !== 1'b1 || dout !== base + 64'(i) || sha_hold !== 1'b1 ||
                    squeeze !== (rem > 21) || dout_last !== (rem == 1)) begin
                    failures++;
                    $display("FAIL multi_b%0d_w%0d: dv=%b dout=%0d hold=%b sq=%b last=%b, want 1 %0d 1 %b %b",
                             b, i, dout_valid, dout, sha_hold, squeeze, dout_last, base + 64'(i), (rem > 21), (rem == 1));
                end
                rem--;
                step();
            end
            blk_valid = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || squeeze !== 1'b0 || sha_hold !== 1'b0) begin
            failures++;
            $display("FAIL multi_done: done=%b sq=%b hold=%b, want 1 0 0", done, squeeze, sha_hold);
        end
        step();
    endtask

    task automatic test_backpressure();
        int pat[6] = '{1, 0, 0, 1, 0, 1};
        int idx;
        int hs;
        idx = 0;
        hs  = 0;
        dout_ready = 1'b0;
        issue_start(2'b00, 3);
        present_block(64'h10);
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== 64'h10 + 64'(idx) || dout_last !== (idx == 2)) begin
                failures++;
                $display("FAIL bp_cycle%0d: dv=%b dout=%h last=%b, want 1 %h %b",
                         c, dout_valid, dout, dout_last, 64'h10 + 64'(idx), (idx == 2));
            end
            dout_ready = pat[c][0];
            if (pat[c] == 1) idx++;
            if (dout_valid && dout_ready) hs++;
            step();
        end
        dout_ready = 1'b1;
        checks++;
        if (hs !== 3 || done !== 1'b1 || dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_done: handshakes=%0d done=%b dv=%b, want 3 1 0", hs, done, dout_valid);
        end
        step();
    endtask

    task automatic test_h_clamp();
        dout_ready = 1'b1;
        issue_start(2'b10, 30);
        checks++;
        if (squeeze !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL h_wait: sq=%b busy=%b, want 0 1", squeeze, busy);
        end
        present_block(64'h500);
        for (int i = 0; i < RATE_OTHER; i++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== 64'h500 + 64'(i) || squeeze !== 1'b0 ||
                dout_last !== (i == RATE_OTHER - 1)) begin
                failures++;
                $display("FAIL h_word%0d: dv=%b dout=%h sq=%b last=%b, want 1 %h 0 %b",
                         i, dout_valid, dout, squeeze, dout_last, 64'h500 + 64'(i), (i == RATE_OTHER - 1));
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL h_done: done=%b dv=%b, want 1 0", done, dout_valid);
        end
        step();
    endtask

    task automatic test_zero_and_ignored();
        dout_ready = 1'b1;
        issue_start(2'b00, 0);
        checks++;
        if (done !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_done: done=%b dv=%b busy=%b, want 1 0 0", done, dout_valid, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_after: done=%b dv=%b, want 0 0", done, dout_valid);
        end
        issue_start(2'b00, 2);
        // Second start while busy asks for many more words; it must be ignored.
        issue_start(2'b00, 40);
        checks++;
        if (squeeze !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL ignored_start: sq=%b busy=%b, want 0 1", squeeze, busy);
        end
        present_block(64'h900);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== 64'h900 + 64'(i) || dout_last !== (i == 1)) begin
                failures++;
                $display("FAIL ignored_word%0d: dv=%b dout=%h last=%b, want 1 %h %b",
                         i, dout_valid, dout, dout_last, 64'h900 + 64'(i), (i == 1));
            end
            step();
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL ignored_done: done=%b, want 1", done);
        end
        step();
    endtask

    task automatic test_reset_mid();
        dout_ready = 1'b1;
        issue_start(2'b00, 10);
        present_block(64'h700);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout !== 64'h700 + 64'(i)) begin
                failures++;
                $display("FAIL rmid_word%0d: dout=%h, want %h", i, dout, 64'h700 + 64'(i));
            end
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({busy, done, dout_valid, dout_last, squeeze, sha_hold} !== 6'b0 || dout !== 64'd0) begin
            failures++;
            $display("FAIL rmid_outputs: busy=%b done=%b dv=%b last=%b sq=%b hold=%b dout=%h, want all 0",
                     busy, done, dout_valid, dout_last, squeeze, sha_hold, dout);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rmid_idle: done=%b busy=%b, want 0 0", done, busy);
        end
        issue_start(2'b11, 2);
        present_block(64'hA00);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== 64'hA00 + 64'(i) || dout_last !== (i == 1)) begin
                failures++;
                $display("FAIL rmid_fresh%0d: dv=%b dout=%h last=%b, want 1 %h %b",
                         i, dout_valid, dout, dout_last, 64'hA00 + 64'(i), (i == 1));
            end
            step();
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL rmid_fresh_done: done=%b, want 1", done);
        end
        step();
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        mode       = 2'b00;
        req_words  = '0;
        blk_in     = '0;
        blk_valid  = 1'b0;
        dout_ready = 1'b0;
        test_reset();
        test_xof_single();
        test_xof_multi();
        test_backpressure();
        test_h_clamp();
        test_zero_and_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
